// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter between the ALU and the load unit. Each
//               requester owns a DEPTH-entry FIFO of {idx, data} writes; the
//               heads are granted round-robin onto the single register-file
//               write port. A given nonzero register index is never buffered
//               in both FIFOs at once, so per-index write order is preserved.
//               Busy flags report pending writes for two read indices.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DEPTH   entries per requester FIFO (power of two, >= 2)
// Ports       : i_clk, i_rst_n                 clock, async active-low reset
//               i_alu_valid/o_alu_ready/i_alu_idx/i_alu_data   ALU request
//               i_lsu_valid/o_lsu_ready/i_lsu_idx/i_lsu_data   LSU request
//               o_rf_write_enable/o_rf_idx/o_rf_data           RF write port
//               i_rd_idx1/2, o_busy1/2          pending-write flags
//               o_byp_hit1/2, o_byp_data1/2     forwarding of the granted
//                                               write (bypass build only)
// Macro       : WB_ARBITER_BYPASS_EN  adds the bypass outputs and removes the
//               granted head from the busy calculation.
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_idx,
    input  logic [31:0] i_alu_data,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_idx,
    input  logic [31:0] i_lsu_data,
    output logic        o_rf_write_enable,
    output logic [4:0]  o_rf_idx,
    output logic [31:0] o_rf_data,
    input  logic [4:0]  i_rd_idx1,
    input  logic [4:0]  i_rd_idx2,
`ifdef WB_ARBITER_BYPASS_EN
    output logic        o_byp_hit1,
    output logic        o_byp_hit2,
    output logic [31:0] o_byp_data1,
    output logic [31:0] o_byp_data2,
`endif
    output logic        o_busy1,
    output logic        o_busy2
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_FULL = (AW+1)'(DEPTH);

    // Requester 0 = ALU, requester 1 = LSU.
    logic [1:0]                  w_in_valid;
    logic [4:0]                  w_in_idx  [2];
    logic [31:0]                 w_in_data [2];
    logic [1:0]                  w_ne, w_full, w_ready_base, w_ready, w_push, w_gnt;
    logic [4:0]                  w_head_idx  [2];
    logic [31:0]                 w_head_data [2];
    logic [1:0][DEPTH-1:0]       w_ent_vld, w_keep, w_m_other, w_m_rd1, w_m_rd2;
    logic [1:0][DEPTH-1:0][4:0]  w_ent_idx;
    logic                        w_tie;
    logic                        last_lsu_q, last_lsu_d;

    assign w_in_valid   = {i_lsu_valid, i_alu_valid};
    assign w_in_idx[0]  = i_alu_idx;
    assign w_in_idx[1]  = i_lsu_idx;
    assign w_in_data[0] = i_alu_data;
    assign w_in_data[1] = i_lsu_data;

    for (genvar r = 0; r < 2; r++) begin : g_req
        logic [4:0]    idx_q  [DEPTH];
        logic [31:0]   data_q [DEPTH];
        logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
        logic [AW:0]   cnt_q, cnt_d;

        assign w_ne[r]          = (cnt_q != '0);
        assign w_full[r]        = (cnt_q == c_FULL);
        // Index 0 is accepted (handshake completes) but never stored.
        assign w_push[r]        = w_in_valid[r] && w_ready[r] && (w_in_idx[r] != 5'd0);
        assign w_head_idx[r]    = idx_q[rd_ptr_q];
        assign w_head_data[r]   = data_q[rd_ptr_q];

        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            // Slot k is occupied when its distance from the read pointer is
            // below the fill count (pointers wrap naturally at DEPTH).
            assign w_ent_vld[r][k] = ({1'b0, AW'(k) - rd_ptr_q} < cnt_q);
            assign w_ent_idx[r][k] = idx_q[k];
`ifdef WB_ARBITER_BYPASS_EN
            // The granted head is forwarded, so it does not stall readers.
            assign w_keep[r][k]    = !(w_gnt[r] && (rd_ptr_q == AW'(k)));
`else
            assign w_keep[r][k]    = 1'b1;
`endif
        end

        always_comb begin
            rd_ptr_d = rd_ptr_q + AW'(w_gnt[r]);
            wr_ptr_d = wr_ptr_q + AW'(w_push[r]);
            cnt_d    = cnt_q + (AW+1)'(w_push[r]) - (AW+1)'(w_gnt[r]);
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: slots are only observed while counted valid.
        always_ff @(posedge i_clk) begin
            if (w_push[r]) begin
                idx_q[wr_ptr_q]  <= w_in_idx[r];
                data_q[wr_ptr_q] <= w_in_data[r];
            end
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_match
        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            assign w_m_other[r][k] = w_ent_vld[1-r][k] && (w_ent_idx[1-r][k] == w_in_idx[r]);
            assign w_m_rd1[r][k]   = w_ent_vld[r][k] && w_keep[r][k] && (w_ent_idx[r][k] == i_rd_idx1);
            assign w_m_rd2[r][k]   = w_ent_vld[r][k] && w_keep[r][k] && (w_ent_idx[r][k] == i_rd_idx2);
        end
        assign w_ready_base[r] = !w_full[r] && !(|w_m_other[r]);
    end

    // Same nonzero index from both units in one cycle: ALU takes it, LSU waits
    // until the ALU copy has drained so the index never sits in both FIFOs.
    assign w_tie      = i_alu_valid && i_lsu_valid && (i_alu_idx == i_lsu_idx) &&
                        (i_alu_idx != 5'd0) && w_ready_base[0];
    assign w_ready[0] = w_ready_base[0];
    assign w_ready[1] = w_ready_base[1] && !w_tie;
    assign o_alu_ready = w_ready[0];
    assign o_lsu_ready = w_ready[1];

    always_comb begin
        w_gnt      = w_ne;
        last_lsu_d = last_lsu_q;
        if (w_ne == 2'b11) begin
            w_gnt = last_lsu_q ? 2'b01 : 2'b10;
        end
        if (|w_gnt) begin
            last_lsu_d = w_gnt[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end

    always_comb begin
        o_rf_write_enable = |w_gnt;
        o_rf_idx          = 5'd0;
        o_rf_data         = 32'd0;
        if (w_gnt[0]) begin
            o_rf_idx  = w_head_idx[0];
            o_rf_data = w_head_data[0];
        end else if (w_gnt[1]) begin
            o_rf_idx  = w_head_idx[1];
            o_rf_data = w_head_data[1];
        end
    end

    assign o_busy1 = (i_rd_idx1 != 5'd0) && (|w_m_rd1);
    assign o_busy2 = (i_rd_idx2 != 5'd0) && (|w_m_rd2);

`ifdef WB_ARBITER_BYPASS_EN
    assign o_byp_hit1  = o_rf_write_enable && (i_rd_idx1 != 5'd0) && (o_rf_idx == i_rd_idx1);
    assign o_byp_hit2  = o_rf_write_enable && (i_rd_idx2 != 5'd0) && (o_rf_idx == i_rd_idx2);
    assign o_byp_data1 = o_byp_hit1 ? o_rf_data : 32'd0;
    assign o_byp_data2 = o_byp_hit2 ? o_rf_data : 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A queue-based reference
//               model predicts readies, the granted write and busy flags
//               every cycle for directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [4:0]  alu_idx, lsu_idx, rd1, rd2, rf_idx;
    logic [31:0] alu_data, lsu_data, rf_data;
    logic        rf_we, busy1, busy2;
`ifdef WB_ARBITER_BYPASS_EN
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_alu_valid       (alu_valid),
        .o_alu_ready       (alu_ready),
        .i_alu_idx         (alu_idx),
        .i_alu_data        (alu_data),
        .i_lsu_valid       (lsu_valid),
        .o_lsu_ready       (lsu_ready),
        .i_lsu_idx         (lsu_idx),
        .i_lsu_data        (lsu_data),
        .o_rf_write_enable (rf_we),
        .o_rf_idx          (rf_idx),
        .o_rf_data         (rf_data),
        .i_rd_idx1         (rd1),
        .i_rd_idx2         (rd2),
`ifdef WB_ARBITER_BYPASS_EN
        .o_byp_hit1        (byp_hit1),
        .o_byp_hit2        (byp_hit2),
        .o_byp_data1       (byp_data1),
        .o_byp_data2       (byp_data2),
`endif
        .o_busy1           (busy1),
        .o_busy2           (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: one queue per requester, oldest first.
    ent_t qa[$];
    ent_t ql[$];
    bit   last_lsu = 1'b1;
    bit   exp_ra, exp_rl;
    int   exp_g;              // -1 none, 0 ALU, 1 LSU

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_queue(input int which, input logic [4:0] idx);
        bit hit = 1'b0;
        if (which == 0) begin
            foreach (qa[i]) if (qa[i].idx == idx) hit = 1'b1;
        end else begin
            foreach (ql[i]) if (ql[i].idx == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    // Pending write to rd; with forwarding enabled the granted head is skipped.
    function automatic bit model_busy(input logic [4:0] rd);
        int  sa = 0;
        int  sl = 0;
        bit  b  = 1'b0;
        if (rd == 5'd0) return 1'b0;
`ifdef WB_ARBITER_BYPASS_EN
        if (exp_g == 0) sa = 1;
        if (exp_g == 1) sl = 1;
`endif
        for (int i = sa; i < qa.size(); i++) if (qa[i].idx == rd) b = 1'b1;
        for (int i = sl; i < ql.size(); i++) if (ql[i].idx == rd) b = 1'b1;
        return b;
    endfunction

    task automatic compare_all();
        logic        e_we;
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        exp_ra = (qa.size() < DEPTH) && !in_queue(1, alu_idx);
        exp_rl = (ql.size() < DEPTH) && !in_queue(0, lsu_idx);
        if (alu_valid && lsu_valid && alu_idx == lsu_idx && alu_idx != 5'd0 && exp_ra)
            exp_rl = 1'b0;
        if (qa.size() > 0 && ql.size() > 0) exp_g = last_lsu ? 0 : 1;
        else if (qa.size() > 0)             exp_g = 0;
        else if (ql.size() > 0)             exp_g = 1;
        else                                exp_g = -1;
        e_we   = (exp_g >= 0);
        e_idx  = (exp_g == 0) ? qa[0].idx  : (exp_g == 1) ? ql[0].idx  : 5'd0;
        e_data = (exp_g == 0) ? qa[0].data : (exp_g == 1) ? ql[0].data : 32'd0;
        check("alu_ready", 32'(alu_ready), 32'(exp_ra));
        check("lsu_ready", 32'(lsu_ready), 32'(exp_rl));
        check("rf_we",     32'(rf_we),     32'(e_we));
        check("rf_idx",    32'(rf_idx),    32'(e_idx));
        check("rf_data",   rf_data,        e_data);
        check("busy1",     32'(busy1),     32'(model_busy(rd1)));
        check("busy2",     32'(busy2),     32'(model_busy(rd2)));
`ifdef WB_ARBITER_BYPASS_EN
        check("byp_hit1",  32'(byp_hit1),  32'(e_we && rd1 != 0 && e_idx == rd1));
        check("byp_hit2",  32'(byp_hit2),  32'(e_we && rd2 != 0 && e_idx == rd2));
        check("byp_data1", byp_data1, (e_we && rd1 != 0 && e_idx == rd1) ? e_data : 32'd0);
        check("byp_data2", byp_data2, (e_we && rd2 != 0 && e_idx == rd2) ? e_data : 32'd0);
`endif
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                        input logic lv, input logic [4:0] li, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        alu_valid = av; alu_idx = ai; alu_data = ad;
        lsu_valid = lv; lsu_idx = li; lsu_data = ld;
        rd1 = r1; rd2 = r2;
        #2;
        compare_all();
        @(posedge clk);
        if (exp_g == 0) void'(qa.pop_front());
        if (exp_g == 1) void'(ql.pop_front());
        if (exp_g >= 0) last_lsu = (exp_g == 1);
        if (av && exp_ra && ai != 5'd0) qa.push_back('{idx: ai, data: ad});
        if (lv && exp_rl && li != 5'd0) ql.push_back('{idx: li, data: ld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is asserted away from an edge and must clear outputs immediately.
    task automatic do_reset();
        @(negedge clk);
        alu_valid = 0; lsu_valid = 0; alu_idx = 0; lsu_idx = 0;
        alu_data = 0; lsu_data = 0; rd1 = 0; rd2 = 0;
        rst_n = 1'b0;
        #2;
        qa.delete();
        ql.delete();
        last_lsu = 1'b1;
        compare_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; lsu_valid = 0; alu_idx = 0; lsu_idx = 0;
        alu_data = 0; lsu_data = 0; rd1 = 0; rd2 = 0;
        do_reset();

        // Single ALU write appears one cycle later, then the port goes idle.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 5, 0);
        idle(1);

        // Two entries per requester drain round-robin as 1,3,2,4.
        step(1, 1, 32'h11, 1, 3, 32'h33, 0, 0);
        step(1, 2, 32'h22, 1, 4, 32'h44, 1, 3);
        step(1, 6, 32'h66, 1, 8, 32'h88, 2, 4);
        idle(5);

        // Index 0 handshakes but writes nothing.
        step(1, 0, 32'h1234, 0, 0, 0, 0, 0);
        idle(2);

        // Same index from both units: ALU first, LSU held off until drained.
        step(1, 7, 32'hA7, 1, 7, 32'hB7, 7, 0);
        step(0, 0, 0, 1, 7, 32'hB7, 0, 7);
        step(0, 0, 0, 1, 7, 32'hB7, 7, 0);
        idle(3);

        // Buffered idx 9 seen by read port 1 while it is the granted head.
        step(1, 9, 32'hCAFE0009, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        idle(1);

        // Reset with three entries buffered drops them all.
        step(1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
        step(1, 3, 32'h3, 1, 4, 32'h4, 0, 0);
        do_reset();
        idle(3);

        // Randomised traffic over a small index range to force conflicts.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
